snake_dir_ctrl: RTL and testbench



---
 rtl/snake_pkg.sv | 23 ++
 rtl/snake_tick_gen.sv | 26 ++
 rtl/snake_dir_ctrl.sv | 105 ++++++++++
 tb/tb_snake_dir_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types for the snake direction controller: heading encoding and FSM states.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DEAD
    } ctrl_state_t;

    // Flipping the high bit maps UP<->DOWN and RIGHT<->LEFT.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Movement-rate divider: counts enabled cycles and flags the wrap at TICK_DIV-1.
module snake_tick_gen #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Combinational so the registered step lands exactly TICK_DIV cycles after start.
    assign tick = en && !clr && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/snake_dir_ctrl.sv
// Snake heading controller: run/pause/dead FSM, 2-deep turn queue with
// reversal filtering, and the periodic movement strobe.
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int   TICK_DIV = 12_500_000,
    parameter dir_t INIT_DIR = DIR_RIGHT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_p,
    input  logic       pause_p,
    input  logic       up_p,
    input  logic       down_p,
    input  logic       left_p,
    input  logic       right_p,
    input  logic       game_over,
    output logic       step,
    output dir_t       heading,
    output logic       running
);
    ctrl_state_t state, state_nx;
    dir_t        q [2];
    logic [1:0]  qcnt;

    logic        tick, do_step, pop, push, press_v, new_game;
    logic [1:0]  cnt_after;
    dir_t        head_nx, ref_dir, press_dir;

    snake_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (state == S_RUN),
        .clr   (state == S_IDLE || state == S_DEAD),
        .tick  (tick)
    );

    always_comb begin
        state_nx = state;
        new_game = 1'b0;
        if (game_over)
            state_nx = S_DEAD;
        else begin
            case (state)
                S_IDLE, S_DEAD: if (start_p) begin
                    state_nx = S_RUN;
                    new_game = 1'b1;
                end
                S_RUN:   if (pause_p) state_nx = S_PAUSE;
                S_PAUSE: if (pause_p) state_nx = S_RUN;
                default: state_nx = state;
            endcase
        end
    end

    always_comb begin
        do_step   = tick && !game_over;
        pop       = do_step && (qcnt != 2'd0);
        head_nx   = pop ? q[0] : heading;
        cnt_after = qcnt - 2'(pop);
        // Tail survives a pop only when the queue held two entries, so q[1] is still the tail.
        ref_dir   = (cnt_after != 2'd0) ? ((qcnt == 2'd2) ? q[1] : q[0]) : head_nx;

        press_v   = up_p || down_p || left_p || right_p;
        if (up_p)        press_dir = DIR_UP;
        else if (down_p) press_dir = DIR_DOWN;
        else if (left_p) press_dir = DIR_LEFT;
        else             press_dir = DIR_RIGHT;

        push = (state == S_RUN) && !game_over && press_v &&
               (press_dir != ref_dir) && (press_dir != opposite(ref_dir)) &&
               (cnt_after != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            heading <= INIT_DIR;
            step    <= 1'b0;
            running <= 1'b0;
            qcnt    <= 2'd0;
            q[0]    <= INIT_DIR;
            q[1]    <= INIT_DIR;
        end else begin
            state   <= state_nx;
            running <= (state_nx == S_RUN);
            step    <= do_step;
            if (game_over) begin
                qcnt <= 2'd0;
            end else if (new_game) begin
                heading <= INIT_DIR;
                qcnt    <= 2'd0;
            end else begin
                heading <= head_nx;
                if (pop)
                    q[0] <= q[1];
                // Later assignment wins, so a push into the slot just vacated by the pop lands correctly.
                if (push)
                    q[cnt_after[0]] <= press_dir;
                qcnt <= cnt_after + 2'(push);
            end
        end
    end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Scoreboard bench: a queue-based game model predicts {step,heading,running} each cycle.
module tb_snake_dir_ctrl;
    import snake_pkg::*;

    localparam int TD = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DEAD = 3;

    logic clk = 1'b0;
    logic reset, start_p, pause_p, up_p, down_p, left_p, right_p, game_over;
    logic step, running;
    dir_t heading;

    always #5 clk = ~clk;

    snake_dir_ctrl #(.TICK_DIV(TD), .INIT_DIR(DIR_RIGHT)) dut (
        .clk       (clk),
        .reset     (reset),
        .start_p   (start_p),
        .pause_p   (pause_p),
        .up_p      (up_p),
        .down_p    (down_p),
        .left_p    (left_p),
        .right_p   (right_p),
        .game_over (game_over),
        .step      (step),
        .heading   (heading),
        .running   (running)
    );

    // Reference model state
    int         m_state, m_cnt;
    logic [1:0] m_head;
    logic       m_step;
    int         m_q[$];
    logic [3:0] exp_q[$];
    int         n_cmp = 0, n_bad = 0, cyc_no = 0;

    task automatic model(input bit rst, st, pa, u, d, l, r, go);
        bit stp;
        int nxt, dir, rf;
        stp = 0;
        if (rst) begin
            m_state = M_IDLE; m_head = 2'd1; m_cnt = 0; m_q.delete();
        end else begin
            nxt = m_state;
            if (m_state == M_RUN && !go && m_cnt == TD - 1) stp = 1;
            if (go) begin
                nxt = M_DEAD; m_q.delete(); m_cnt = 0;
            end else if (m_state == M_IDLE || m_state == M_DEAD) begin
                m_cnt = 0;
                if (st) begin nxt = M_RUN; m_head = 2'd1; m_q.delete(); end
            end else if (m_state == M_PAUSE) begin
                if (pa) nxt = M_RUN;
            end else begin
                if (stp) begin
                    m_cnt = 0;
                    if (m_q.size() > 0) m_head = 2'(m_q.pop_front());
                end else m_cnt++;
                if (u || d || l || r) begin
                    dir = u ? 0 : d ? 2 : l ? 3 : 1;
                    rf  = (m_q.size() > 0) ? m_q[$] : int'(m_head);
                    if (dir != rf && dir != (rf ^ 2) && m_q.size() < 2) m_q.push_back(dir);
                end
                if (pa) nxt = M_PAUSE;
            end
            m_state = nxt;
        end
        m_step = stp;
        exp_q.push_back({m_step, m_head, (m_state == M_RUN)});
    endtask

    // v = {reset, start, pause, up, down, left, right, game_over}
    task automatic cyc(input logic [7:0] v);
        @(negedge clk);
        {reset, start_p, pause_p, up_p, down_p, left_p, right_p, game_over} = v;
        model(v[7], v[6], v[5], v[4], v[3], v[2], v[1], v[0]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(8'b0);
    endtask

    // Monitor: every DUT output cycle is compared against the oldest prediction.
    initial begin
        logic [3:0] want, got;
        forever begin
            @(posedge clk);
            #2;
            cyc_no++;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                got  = {step, heading, running};
                n_cmp++;
                if (got !== want) begin
                    n_bad++;
                    $display("FAIL outputs cyc %0d {step,heading,running} got %b want %b", cyc_no, got, want);
                end
            end
        end
    end

    localparam logic [7:0] RST = 8'h80, ST = 8'h40, PA = 8'h20, UP = 8'h10,
                           DN = 8'h08, LT = 8'h04, RT = 8'h02, GO = 8'h01;

    initial begin
        {reset, start_p, pause_p, up_p, down_p, left_p, right_p, game_over} = '0;
        reset = 1'b1;
        cyc(RST); cyc(RST);
        // Plain run: steps every TD cycles, heading stays RIGHT
        cyc(ST); idle(13);
        // Reversal and same-direction presses rejected
        cyc(RST); cyc(ST); idle(2); cyc(LT); cyc(RT); idle(6);
        // Two queued turns, third press dropped on a full queue
        cyc(RST); cyc(ST); cyc(UP); cyc(LT); cyc(DN); idle(10);
        // Simultaneous presses, then push coinciding with pop on a full queue
        cyc(RST); cyc(ST); cyc(UP | DN); idle(6);
        cyc(RST); cyc(ST); cyc(UP); cyc(LT); cyc(8'b0); cyc(DN); idle(10);
        // Pause holds counter and ignores presses
        cyc(RST); cyc(ST); cyc(8'b0); cyc(PA); cyc(UP); cyc(LT); idle(5); cyc(PA); idle(6);
        // game_over beats start; restart; reset mid-run
        cyc(RST); cyc(ST); cyc(UP); idle(4); cyc(DN); cyc(GO | ST); idle(3);
        cyc(ST); idle(6); cyc(RST | ST | UP); idle(3);
        // Randomized play
        for (int i = 0; i < 4000; i++) begin
            logic [7:0] v;
            v = 8'b0;
            v[7] = ($urandom_range(0, 299) == 0);
            v[6] = ($urandom_range(0, 29) == 0);
            v[5] = ($urandom_range(0, 24) == 0);
            v[4] = ($urandom_range(0, 5) == 0);
            v[3] = ($urandom_range(0, 5) == 0);
            v[2] = ($urandom_range(0, 5) == 0);
            v[1] = ($urandom_range(0, 5) == 0);
            v[0] = ($urandom_range(0, 79) == 0);
            cyc(v);
        end
        @(negedge clk);
        {reset, start_p, pause_p, up_p, down_p, left_p, right_p, game_over} = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain pending %0d want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
